// File: rtl/sad_min_search.sv
// Motion-search decision stage: walks a (2*SR+1)^2 candidate window in raster
// order, tracks the minimum SAD and strobes the winning motion vector.
module sad_min_search #(
  parameter int DWIDTH = 8,
  parameter int SR     = 4,
  parameter int MV_W   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [DWIDTH+7:0]        sad,
  input  logic                     sad_vld,
  output logic                     busy,
  output logic signed [MV_W-1:0]   cand_x,
  output logic signed [MV_W-1:0]   cand_y,
  output logic [DWIDTH+7:0]        best_sad,
  output logic signed [MV_W-1:0]   best_mvx,
  output logic signed [MV_W-1:0]   best_mvy,
  output logic                     result_vld
);
  localparam int SW    = DWIDTH + 8;
  localparam int NCAND = (2*SR+1) * (2*SR+1);
  localparam int CW    = $clog2(NCAND);
  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-SR);
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(SR);
  localparam logic signed [MV_W-1:0] MV_ONE = MV_W'(1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    min_vld_q;
  logic [SW-1:0]           min_sad_q, min_sad_d;
  logic signed [MV_W-1:0]  min_x_q, min_x_d, min_y_q, min_y_d;
  logic                    busy_q, rvld_q;
  logic signed [MV_W-1:0]  cx_q, cy_q, bx_q, by_q;
  logic [SW-1:0]           bsad_q;
  logic                    take, last;

  // First candidate always wins; later ones only if strictly smaller, so
  // ties keep the earlier raster position.
  assign take = !min_vld_q || (sad < min_sad_q);
  assign last = (cnt_q == CW'(NCAND-1));

  always_comb begin
    min_sad_d = min_sad_q;
    min_x_d   = min_x_q;
    min_y_d   = min_y_q;
    if (take) begin
      min_sad_d = sad;
      min_x_d   = cx_q;
      min_y_d   = cy_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      min_vld_q <= 1'b0;
      min_sad_q <= '0;
      min_x_q   <= '0;
      min_y_q   <= '0;
      busy_q    <= 1'b0;
      rvld_q    <= 1'b0;
      cx_q      <= '0;
      cy_q      <= '0;
      bsad_q    <= '0;
      bx_q      <= '0;
      by_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rvld_q <= 1'b0;
          if (start) begin
            state_q   <= SEARCH;
            busy_q    <= 1'b1;
            cx_q      <= MV_MIN;
            cy_q      <= MV_MIN;
            cnt_q     <= '0;
            min_vld_q <= 1'b0;
          end
        end
        SEARCH: begin
          if (sad_vld) begin
            min_vld_q <= 1'b1;
            min_sad_q <= min_sad_d;
            min_x_q   <= min_x_d;
            min_y_q   <= min_y_d;
            if (last) begin
              // Offsets stay at (+SR,+SR) so cand_y never overflows MV_W.
              state_q <= DONE;
              bsad_q  <= min_sad_d;
              bx_q    <= min_x_d;
              by_q    <= min_y_d;
              rvld_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
              if (cx_q == MV_MAX) begin
                cx_q <= MV_MIN;
                cy_q <= cy_q + MV_ONE;
              end else begin
                cx_q <= cx_q + MV_ONE;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rvld_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign cand_x     = cx_q;
  assign cand_y     = cy_q;
  assign best_sad   = bsad_q;
  assign best_mvx   = bx_q;
  assign best_mvy   = by_q;
  assign result_vld = rvld_q;
endmodule
